// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing the two ports of an asynchronous dual-port RAM among
// NUM_REQ requesters, with registered RAM drive and a fixed 2-cycle read latency.

module dpram_port_arbiter_rsp_lane #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hit_a,
    input  logic                  hit_b,
    input  logic [DATA_WIDTH-1:0] rdata_a,
    input  logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata
);
    // A requester owns at most one port per cycle, so hit_a and hit_b are exclusive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= hit_a | hit_b;
            if (hit_a)
                rsp_rdata <= rdata_a;
            else if (hit_b)
                rsp_rdata <= rdata_b;
        end
    end
endmodule

module dpram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_rdata,
    output logic [ADDR_WIDTH-1:0]            ram_addr_a,
    output logic [ADDR_WIDTH-1:0]            ram_addr_b,
    output logic [DATA_WIDTH-1:0]            ram_wdata_a,
    output logic [DATA_WIDTH-1:0]            ram_wdata_b,
    output logic                             ram_we_a,
    output logic                             ram_we_b,
    output logic                             ram_re_a,
    output logic                             ram_re_b,
    input  logic [DATA_WIDTH-1:0]            ram_rdata_a,
    input  logic [DATA_WIDTH-1:0]            ram_rdata_b,
    output logic [7:0]                       hazard_cnt
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    req_t             req [NUM_REQ];
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx_a;
    logic [IDX_W-1:0] idx_b;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] sel_a;
    logic [IDX_W-1:0] sel_b;
    logic             found_a;
    logic             found_b;
    logic             hazard;
    logic             grant_b;
    logic [NUM_REQ-1:0] hit_a;
    logic [NUM_REQ-1:0] hit_b;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ)
            s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign req[i] = '{write: req_write[i],
                          addr:  req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                          wdata: req_wdata[i*DATA_WIDTH +: DATA_WIDTH]};
    end

    // First two valid requesters in round-robin order from the pointer.
    always_comb begin
        found_a = 1'b0;
        found_b = 1'b0;
        idx_a   = '0;
        idx_b   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_valid[wrap_idx(ptr, k)]) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    idx_a   = wrap_idx(ptr, k);
                end else if (!found_b) begin
                    found_b = 1'b1;
                    idx_b   = wrap_idx(ptr, k);
                end
            end
        end
    end

    // Read/read to one address is harmless; anything involving a write is deferred.
    assign hazard   = found_b && (req[idx_a].addr == req[idx_b].addr)
                      && (req[idx_a].write || req[idx_b].write);
    assign grant_b  = found_b && !hazard;
    assign last_idx = grant_b ? idx_b : idx_a;

    always_comb begin
        req_ready = '0;
        if (found_a)
            req_ready[idx_a] = 1'b1;
        if (grant_b)
            req_ready[idx_b] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            hazard_cnt <= '0;
        end else begin
            if (found_a)
                ptr <= (last_idx == IDX_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
            if (hazard && hazard_cnt != 8'hFF)
                hazard_cnt <= hazard_cnt + 8'd1;
        end
    end

    // RAM pins come straight from flops so the async RAM never sees a glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_we_a    <= 1'b0;
            ram_re_a    <= 1'b0;
            ram_addr_a  <= '0;
            ram_wdata_a <= '0;
            sel_a       <= '0;
        end else begin
            ram_we_a <= found_a && req[idx_a].write;
            ram_re_a <= found_a && !req[idx_a].write;
            if (found_a) begin
                ram_addr_a  <= req[idx_a].addr;
                ram_wdata_a <= req[idx_a].wdata;
                sel_a       <= idx_a;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_we_b    <= 1'b0;
            ram_re_b    <= 1'b0;
            ram_addr_b  <= '0;
            ram_wdata_b <= '0;
            sel_b       <= '0;
        end else begin
            ram_we_b <= grant_b && req[idx_b].write;
            ram_re_b <= grant_b && !req[idx_b].write;
            if (grant_b) begin
                ram_addr_b  <= req[idx_b].addr;
                ram_wdata_b <= req[idx_b].wdata;
                sel_b       <= idx_b;
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
        assign hit_a[i] = ram_re_a && (sel_a == IDX_W'(i));
        assign hit_b[i] = ram_re_b && (sel_b == IDX_W'(i));

        dpram_port_arbiter_rsp_lane #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .hit_a     (hit_a[i]),
            .hit_b     (hit_b[i]),
            .rdata_a   (ram_rdata_a),
            .rdata_b   (ram_rdata_b),
            .rsp_valid (rsp_valid[i]),
            .rsp_rdata (rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Random and directed traffic against a rule-level arbiter/memory model; read data is
// checked by a scoreboard monitor decoupled from the stimulus.
module tb_dpram_port_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid, req_write, req_ready, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata, rsp_rdata;
    logic [AW-1:0]     ram_addr_a, ram_addr_b;
    logic [DW-1:0]     ram_wdata_a, ram_wdata_b, ram_rdata_a, ram_rdata_b;
    logic              ram_we_a, ram_we_b, ram_re_a, ram_re_b;
    logic [7:0]        hazard_cnt;

    dpram_port_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
        .ram_wdata_a(ram_wdata_a), .ram_wdata_b(ram_wdata_b),
        .ram_we_a(ram_we_a), .ram_we_b(ram_we_b), .ram_re_a(ram_re_a), .ram_re_b(ram_re_b),
        .ram_rdata_a(ram_rdata_a), .ram_rdata_b(ram_rdata_b), .hazard_cnt(hazard_cnt));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Async-read RAM whose writes land on the clock edge ending the enable cycle.
    logic [DW-1:0] ram_mem [16];
    always @(posedge clk) begin
        if (ram_we_a) ram_mem[ram_addr_a] <= ram_wdata_a;
        if (ram_we_b) ram_mem[ram_addr_b] <= ram_wdata_b;
    end
    assign ram_rdata_a = ram_mem[ram_addr_a];
    assign ram_rdata_b = ram_mem[ram_addr_b];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rsp_t;
    rsp_t rq [NR][$];

    // Pending requests (held until accepted) and the reference model state.
    logic [NR-1:0] p_valid, p_write;
    logic [AW-1:0] p_addr  [NR];
    logic [DW-1:0] p_wdata [NR];
    logic [DW-1:0] m_mem   [16];
    logic [DW-1:0] last_rsp [NR];
    int            m_ptr, m_hcnt;
    logic          e_we_a, e_re_a, e_we_b, e_re_b;
    logic [AW-1:0] e_addr_a, e_addr_b;
    logic [DW-1:0] e_wdata_a, e_wdata_b;

    task automatic issue(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_valid[i] = 1'b1;
        p_write[i] = w;
        p_addr[i]  = a;
        p_wdata[i] = d;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_hcnt = 0;
        e_we_a = 0; e_re_a = 0; e_we_b = 0; e_re_b = 0;
        e_addr_a = '0; e_addr_b = '0; e_wdata_a = '0; e_wdata_b = '0;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step();
        int order[$];
        int a, b;
        bit ga, fb, hz, gb;
        logic [NR-1:0] exp_ready;
        check("port_a", 64'({ram_we_a, ram_re_a, ram_addr_a, ram_wdata_a}),
                        64'({e_we_a, e_re_a, e_addr_a, e_wdata_a}));
        check("port_b", 64'({ram_we_b, ram_re_b, ram_addr_b, ram_wdata_b}),
                        64'({e_we_b, e_re_b, e_addr_b, e_wdata_b}));
        check("hazard_cnt", 64'(hazard_cnt), 64'(m_hcnt));
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = p_addr[i];
            req_wdata[i*DW +: DW] = p_wdata[i];
        end
        req_valid = p_valid;
        req_write = p_write;
        #1;
        for (int k = 0; k < NR; k++)
            if (p_valid[(m_ptr + k) % NR]) order.push_back((m_ptr + k) % NR);
        ga = order.size() > 0;
        fb = order.size() > 1;
        a  = ga ? order[0] : 0;
        b  = fb ? order[1] : 0;
        hz = fb && (p_addr[a] == p_addr[b]) && (p_write[a] || p_write[b]);
        gb = fb && !hz;
        exp_ready = '0;
        if (ga) exp_ready[a] = 1'b1;
        if (gb) exp_ready[b] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        e_we_a = ga && p_write[a];  e_re_a = ga && !p_write[a];
        e_we_b = gb && p_write[b];  e_re_b = gb && !p_write[b];
        if (ga) begin e_addr_a = p_addr[a]; e_wdata_a = p_wdata[a]; end
        if (gb) begin e_addr_b = p_addr[b]; e_wdata_b = p_wdata[b]; end
        // Reads see memory before this cycle's writes.
        if (e_re_a) rq[a].push_back('{m_mem[p_addr[a]], cyc + 2});
        if (e_re_b) rq[b].push_back('{m_mem[p_addr[b]], cyc + 2});
        if (e_we_a) m_mem[p_addr[a]] = p_wdata[a];
        if (e_we_b) m_mem[p_addr[b]] = p_wdata[b];
        if (hz && m_hcnt < 255) m_hcnt++;
        if (gb) m_ptr = (b + 1) % NR;
        else if (ga) m_ptr = (a + 1) % NR;
        if (ga) p_valid[a] = 1'b0;
        if (gb) p_valid[b] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic apply_reset(input int hold);
        reset = 1'b1;
        for (int i = 0; i < NR; i++) rq[i].delete();
        p_valid = '0;
        req_valid = '0;
        model_reset();
        repeat (hold) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NR; i++) begin
                if (rq[i].size() > 0 && rq[i][0].due < cyc) begin
                    check("rsp_missing_due", 64'(cyc), 64'(rq[i][0].due));
                    void'(rq[i].pop_front());
                end
                if (rsp_valid[i]) begin
                    if (rq[i].size() == 0) begin
                        check("rsp_unexpected", 64'(rsp_valid[i]), 64'(0));
                    end else begin
                        rsp_t e;
                        e = rq[i].pop_front();
                        check("rsp_rdata", 64'(rsp_rdata[i*DW +: DW]), 64'(e.data));
                        check("rsp_latency", 64'(cyc), 64'(e.due));
                    end
                    last_rsp[i] = rsp_rdata[i*DW +: DW];
                end
            end
            if (ram_we_a && ram_we_b)
                check("we_same_addr", 64'(ram_addr_a != ram_addr_b), 64'(1));
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin ram_mem[i] = '0; m_mem[i] = '0; end
        for (int i = 0; i < NR; i++) begin
            p_addr[i] = '0; p_wdata[i] = '0; last_rsp[i] = '0;
        end
        p_write = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        apply_reset(3);
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_ready", 64'(req_ready), 64'(0));

        // Write then read-back two cycles later.
        issue(0, 1'b1, 4'd3, 8'h5A);
        step(); step();
        issue(1, 1'b0, 4'd3, 8'h00);
        step(); idle(4);
        check("t1_rdata", 64'(last_rsp[1]), 64'(8'h5A));

        // Same-address write/write: one deferred.
        apply_reset(2);
        issue(0, 1'b1, 4'd7, 8'h11);
        issue(1, 1'b1, 4'd7, 8'h22);
        idle(4);
        check("t2_hazard_cnt", 64'(hazard_cnt), 64'(1));
        check("t2_mem7", 64'(ram_mem[7]), 64'(8'h22));

        // Read/read to the same address is granted on both ports.
        apply_reset(2);
        issue(0, 1'b1, 4'd5, 8'hAA);
        idle(3);
        issue(2, 1'b0, 4'd5, 8'h00);
        issue(3, 1'b0, 4'd5, 8'h00);
        idle(4);
        check("t3_rdata2", 64'(last_rsp[2]), 64'(8'hAA));
        check("t3_rdata3", 64'(last_rsp[3]), 64'(8'hAA));
        check("t3_hazard_cnt", 64'(hazard_cnt), 64'(0));

        // Reset in the cycle after a read is accepted drops its response.
        issue(1, 1'b0, 4'd9, 8'h00);
        step();
        apply_reset(1);
        check("t5_rsp_valid", 64'(rsp_valid), 64'(0));
        check("t5_ram_pins", 64'({ram_we_a, ram_re_a, ram_addr_a, ram_wdata_a,
                                  ram_we_b, ram_re_b, ram_addr_b, ram_wdata_b}), 64'(0));
        check("t5_hazard_cnt", 64'(hazard_cnt), 64'(0));

        // All four continuously valid: pairs (0,1),(2,3),... from pointer 0.
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NR; i++)
                if (!p_valid[i]) issue(i, 1'b0, 4'(i + 8), 8'h00);
            step();
        end
        p_valid = '0;
        idle(4);

        // Continuous same-address write hazards saturate the counter.
        apply_reset(2);
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 2; i++)
                if (!p_valid[i]) issue(i, 1'b1, 4'd2, 8'($urandom));
            step();
        end
        p_valid = '0;
        idle(3);
        check("t6_hazard_sat", 64'(hazard_cnt), 64'(255));

        // Random traffic; narrow address window half the time to force hazards.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NR; i++)
                if (!p_valid[i] && $urandom_range(0, 1) == 1)
                    issue(i, 1'($urandom_range(0, 1)),
                          4'((c % 200 < 100) ? $urandom_range(0, 3) : $urandom_range(0, 15)),
                          8'($urandom));
            step();
        end
        p_valid = '0;
        idle(5);
        for (int i = 0; i < NR; i++)
            check("rsp_queue_drained", 64'(rq[i].size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Synchronous round-robin arbiter that shares the two ports of the team's asynchronous dual-port RAM among NUM_REQ requesters.
- Each cycle it grants up to two requests, one to RAM port A and one to RAM port B.
- It never issues two conflicting accesses to the same address in the same cycle, so the RAM's write-conflict flag never fires in normal operation.
- It sits between client engines and the RAM and drives the RAM's enable, address and data pins from registers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, RAM data width.
- ADDR_WIDTH, 4, RAM address width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_write  input  NUM_REQ  1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i.
- req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data.
- req_ready  output  NUM_REQ  accept strobe; handshake completes when valid&ready.
- rsp_valid  output  NUM_REQ  one-cycle pulse carrying read data.
- rsp_rdata  output  NUM_REQ*DATA_WIDTH  packed read data; valid only with rsp_valid.
- ram_addr_a, ram_addr_b  output  ADDR_WIDTH  RAM port addresses.
- ram_wdata_a, ram_wdata_b  output  DATA_WIDTH  RAM write data.
- ram_we_a, ram_we_b  output  1  RAM write enables.
- ram_re_a, ram_re_b  output  1  RAM read enables.
- ram_rdata_a, ram_rdata_b  input  DATA_WIDTH  RAM read data.
- hazard_cnt  output  8  count of deferred grants; saturates at 255.

Behaviour:
- Reset:
  - All outputs go to 0 and the round-robin pointer goes to 0.
  - In-flight reads are discarded; no rsp_valid follows a reset.
  - This applies regardless of the cycle in which reset asserts.
- Requester rules:
  - A requester holds valid, write, addr and wdata stable until it sees ready.
  - req_ready is combinational from the current inputs and pointer, and is high only in the acceptance cycle.
- Arbitration, cycle N:
  - Scan valid requesters starting at the pointer and wrapping modulo NUM_REQ.
  - The first found is the A-candidate; the next is the B-candidate.
  - The A-candidate is always granted if present.
  - The B-candidate is granted unless it hazards with the A-candidate.
  - A hazard is same address AND at least one of the two is a write. Read/read to the same address is allowed.
  - A hazarded B-candidate is not granted, and the scan does not search further that cycle.
  - hazard_cnt increments by 1 for each deferral.
- Pointer update:
  - pointer <= (last granted index + 1) mod NUM_REQ.
  - If nothing is granted, the pointer is unchanged.
- Issue, cycle N+1:
  - ram_* outputs are registered from the cycle-N grants.
  - Enables are high for exactly one cycle per grant. Addr and wdata are held until the next grant.
  - Ports with no grant get we=0 and re=0.
  - Write-enable and address change only on clock edges, so the async RAM sees no glitches.
- Read response:
  - At the end of cycle N+1, ram_rdata_x is registered into the granted requester's rsp_rdata slice.
  - rsp_valid pulses in cycle N+2, giving a fixed 2-cycle accept-to-data latency.
  - Writes produce no response.
- Ordering within a cycle:
  - A read granted in the same cycle as a write to a different address returns pre-existing memory.
  - A later-cycle read after a write returns the new data, since the write lands in N+1.
- Throughput:
  - Up to 2 grants per cycle; back-to-back acceptance is allowed for the same requester.
  - One requester never receives both ports in the same cycle.
- Fairness: any continuously valid requester is granted within ceil(NUM_REQ/1) cycles, since the pointer always moves past the last grant.

Test Plan:
- Reset, then requester 0 writes addr 3 data 0x5A, then requester 1 reads addr 3 two cycles later -> ram_we_a pulses with ram_addr_a=3 and ram_wdata_a=0x5A; requester 1 sees rsp_valid at accept+2 with rdata 0x5A.
- Requesters 0 and 1 both write addr 7 (0x11, 0x22) in the same cycle -> only 0 ready in cycle N; 1 ready in N+1; hazard_cnt=1; final memory at 7 = 0x22; ram_we_a and ram_we_b never both high to addr 7.
- Requesters 2 and 3 read addr 5 (preloaded 0xAA) in the same cycle -> both granted, A=2 and B=3; both rsp_valid at N+2 with 0xAA; hazard_cnt=0.
- All 4 requesters continuously valid with reads to distinct addresses for 8 cycles -> grant pairs (0,1),(2,3),(0,1),... with every requester granted every 2 cycles.
- Requester 1 read accepted, reset asserted in cycle N+1 -> no rsp_valid in N+2; all ram_* = 0; pointer 0; hazard_cnt = 0.
- 300 forced same-address write hazards -> hazard_cnt saturates at 255.
